// File: rtl/bus_arbiter_split.sv
// Two-master bus arbiter with split/resume; ARB_ROUND_ROBIN_EN selects round-robin over fixed M1 priority.
// Latency: grant 1 cycle after a sampled request in IDLE; release then GRANT_GAP idle turnaround cycles.
// Backpressure: no grants while sready=0 in IDLE; split masters stay ineligible until their resume.
module bus_arbiter_split #(
  parameter int GRANT_GAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  input  logic sready,
  input  logic s_split,
  input  logic s_split_done,
  output logic m1_split,
  output logic m2_split,
  output logic split_grant,
  output logic bus_busy
);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, GAP} state_t;

  localparam logic [3:0] GAP_LOAD  = (GRANT_GAP > 0) ? 4'(GRANT_GAP - 1) : 4'd0;
  localparam state_t     REL_STATE = (GRANT_GAP > 0) ? GAP : IDLE;
  localparam logic       REL_BUSY  = (GRANT_GAP > 0);

  state_t     state;
  logic [3:0] gap_cnt;
  logic       pending;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_m1;  // 1 = master 1 held the most recent grant
`endif

  logic split_out;
  logic elig1;
  logic elig2;
  logic pick_m2;
  logic take_m2;
  logic grant_go;
  logic own_req;
  logic do_split;

  always_comb begin
    split_out = m1_split | m2_split;
    elig1     = m1_breq & ~m1_split;
    elig2     = m2_breq & ~m2_split;
`ifdef ARB_ROUND_ROBIN_EN
    pick_m2   = elig2 & (~elig1 | last_m1);
`else
    pick_m2   = elig2 & ~elig1;
`endif
    // a resumed split master wins over any fresh request
    take_m2   = pending ? m2_split : pick_m2;
    grant_go  = sready & (pending | elig1 | elig2);
    own_req   = (state == OWN1) ? m1_breq : m2_breq;
    do_split  = s_split & ~split_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= 4'd0;
      pending     <= 1'b0;
      m1_bgrant   <= 1'b0;
      m2_bgrant   <= 1'b0;
      msel        <= 1'b0;
      m1_split    <= 1'b0;
      m2_split    <= 1'b0;
      split_grant <= 1'b0;
      bus_busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1     <= 1'b0;
`endif
    end else begin
      split_grant <= 1'b0;
      if (split_out && s_split_done)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_go) begin
            state     <= take_m2 ? OWN2 : OWN1;
            m1_bgrant <= ~take_m2;
            m2_bgrant <= take_m2;
            msel      <= take_m2;
            bus_busy  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_m1   <= ~take_m2;
`endif
            if (pending) begin
              split_grant <= 1'b1;
              pending     <= 1'b0;
              m1_split    <= 1'b0;
              m2_split    <= 1'b0;
            end
          end
        end

        OWN1, OWN2: begin
          if (do_split || !own_req) begin
            if (do_split) begin
              m1_split <= (state == OWN1);
              m2_split <= (state == OWN2);
            end
            m1_bgrant <= 1'b0;
            m2_bgrant <= 1'b0;
            state     <= REL_STATE;
            gap_cnt   <= GAP_LOAD;
            bus_busy  <= REL_BUSY;
          end
        end

        GAP: begin
          if (gap_cnt == 4'd0) begin
            state    <= IDLE;
            bus_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
